// File: rtl/cacheline_adaptor_if.sv
// Bus bundle between the last-level cache, the cacheline adaptor and burst memory.
// The adaptor takes the slave view; the cache/memory side (or a bench) takes master.
interface cacheline_adaptor_if #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64,
  parameter int ADDR_W  = 32
);
  logic [LINE_W-1:0]  line_i;
  logic [LINE_W-1:0]  line_o;
  logic [ADDR_W-1:0]  address_i;
  logic               read_i;
  logic               write_i;
  logic               resp_o;
  logic [BURST_W-1:0] burst_i;
  logic [BURST_W-1:0] burst_o;
  logic [ADDR_W-1:0]  address_o;
  logic               read_o;
  logic               write_o;
  logic               resp_i;

  modport slave (
    input  line_i, address_i, read_i, write_i, burst_i, resp_i,
    output line_o, resp_o, burst_o, address_o, read_o, write_o
  );

  modport master (
    output line_i, address_i, read_i, write_i, burst_i, resp_i,
    input  line_o, resp_o, burst_o, address_o, read_o, write_o
  );
endinterface

// File: rtl/cacheline_adaptor.sv
// Converts one cache-line read/write into a BEATS-long memory burst, assembling or
// splitting the line, and acknowledges the cache with a single-cycle pulse.
module cacheline_adaptor #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64,
  parameter int ADDR_W  = 32
) (
  input logic              clk,
  input logic              rst_n,
  cacheline_adaptor_if.slave bus
);
  localparam int BEATS = LINE_W / BURST_W;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(LINE_W / 8 - 1);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_nxt;
  logic              last_beat;
  logic [LINE_W-1:0] line_q;

  assign cnt_nxt   = cnt + CW'(1);
  assign last_beat = (cnt == CW'(BEATS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      line_q        <= '0;
      bus.line_o    <= '0;
      bus.burst_o   <= '0;
      bus.address_o <= '0;
      bus.read_o    <= 1'b0;
      bus.write_o   <= 1'b0;
      bus.resp_o    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.resp_o <= 1'b0;
          // Read wins when both requests are raised together.
          if (bus.read_i) begin
            bus.address_o <= bus.address_i & ALIGN_MASK;
            cnt           <= '0;
            bus.read_o    <= 1'b1;
            state         <= RD;
          end else if (bus.write_i) begin
            bus.address_o <= bus.address_i & ALIGN_MASK;
            line_q        <= bus.line_i;
            cnt           <= '0;
            bus.burst_o   <= bus.line_i[BURST_W-1:0];
            bus.write_o   <= 1'b1;
            state         <= WR;
          end
        end
        RD: begin
          if (bus.resp_i) begin
            bus.line_o[int'(cnt)*BURST_W +: BURST_W] <= bus.burst_i;
            cnt <= cnt_nxt;
            if (last_beat) begin
              bus.read_o <= 1'b0;
              bus.resp_o <= 1'b1;
              state      <= DONE;
            end
          end
        end
        WR: begin
          // Preload the following beat so burst_o is valid the cycle after each accept.
          if (bus.resp_i) begin
            cnt         <= cnt_nxt;
            bus.burst_o <= line_q[int'(cnt_nxt)*BURST_W +: BURST_W];
            if (last_beat) begin
              bus.write_o <= 1'b0;
              bus.resp_o  <= 1'b1;
              state       <= DONE;
            end
          end
        end
        DONE: begin
          bus.resp_o <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor: inputs driven and outputs sampled on negedge.
module tb_cacheline_adaptor;
  localparam int LINE_W  = 256;
  localparam int BURST_W = 64;
  localparam int ADDR_W  = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  cacheline_adaptor_if #(.LINE_W(LINE_W), .BURST_W(BURST_W), .ADDR_W(ADDR_W)) bus ();

  cacheline_adaptor #(.LINE_W(LINE_W), .BURST_W(BURST_W), .ADDR_W(ADDR_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [63:0] rd_beats [4] = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                                64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
  logic [255:0] rd_line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                           64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
  logic [63:0] wr_beats [4] = '{64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB,
                                64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD};
  logic [255:0] wr_line = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                           64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
  logic [63:0] gp_beats [4] = '{64'h0101_0101_0101_0101, 64'h0202_0202_0202_0202,
                                64'h0303_0303_0303_0303, 64'h0404_0404_0404_0404};
  logic [255:0] gp_line = {64'h0404_0404_0404_0404, 64'h0303_0303_0303_0303,
                           64'h0202_0202_0202_0202, 64'h0101_0101_0101_0101};
  logic [63:0] bh_beats [4] = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                                64'h0F0F_0F0F_F0F0_F0F0, 64'h5A5A_A5A5_5A5A_A5A5};
  logic [255:0] bh_line = {64'h5A5A_A5A5_5A5A_A5A5, 64'h0F0F_0F0F_F0F0_F0F0,
                           64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF};
  logic [63:0] rs_beats [4] = '{64'h9000_0000_0000_0009, 64'h8000_0000_0000_0008,
                                64'h7000_0000_0000_0007, 64'h6000_0000_0000_0006};
  logic [255:0] rs_line = {64'h6000_0000_0000_0006, 64'h7000_0000_0000_0007,
                           64'h8000_0000_0000_0008, 64'h9000_0000_0000_0009};
  logic [255:0] bb_line = {64'hCAFE_F00D_0000_0004, 64'hCAFE_F00D_0000_0003,
                           64'hCAFE_F00D_0000_0002, 64'hCAFE_F00D_0000_0001};
  logic [63:0] mem [4];

  task automatic idle_inputs();
    bus.line_i    = '0;
    bus.address_i = '0;
    bus.read_i    = 1'b0;
    bus.write_i   = 1'b0;
    bus.burst_i   = '0;
    bus.resp_i    = 1'b0;
  endtask

  // Zero-wait memory backed by a single line; beat position tracked per burst.
  task automatic mem_serve(output bit done);
    int unsigned mb = 0;
    done = 1'b0;
    for (int unsigned c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.resp_o) begin
        done = 1'b1;
        bus.resp_i = 1'b0;
        break;
      end
      if (bus.write_o) begin
        mem[mb % 4] = bus.burst_o;
        bus.resp_i = 1'b1;
        mb++;
      end else if (bus.read_o) begin
        bus.burst_i = mem[mb % 4];
        bus.resp_i = 1'b1;
        mb++;
      end else begin
        bus.resp_i = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    checks++; if (bus.line_o !== '0) begin failures++; $display("FAIL reset_line_o actual=%h required=0", bus.line_o); end
    checks++; if (bus.burst_o !== '0) begin failures++; $display("FAIL reset_burst_o actual=%h required=0", bus.burst_o); end
    checks++; if (bus.address_o !== '0) begin failures++; $display("FAIL reset_address_o actual=%h required=0", bus.address_o); end
    checks++; if (bus.read_o !== 1'b0) begin failures++; $display("FAIL reset_read_o actual=%b required=0", bus.read_o); end
    checks++; if (bus.write_o !== 1'b0) begin failures++; $display("FAIL reset_write_o actual=%b required=0", bus.write_o); end
    checks++; if (bus.resp_o !== 1'b0) begin failures++; $display("FAIL reset_resp_o actual=%b required=0", bus.resp_o); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read_zero_wait();
    bus.read_i    = 1'b1;
    bus.address_i = 32'h0000_1234;
    @(negedge clk);
    for (int unsigned k = 0; k < 4; k++) begin
      checks++; if (bus.read_o !== 1'b1) begin failures++; $display("FAIL rd_read_o beat=%0d actual=%b required=1", k, bus.read_o); end
      checks++; if (bus.resp_o !== 1'b0) begin failures++; $display("FAIL rd_early_resp beat=%0d actual=%b required=0", k, bus.resp_o); end
      checks++; if (bus.address_o !== 32'h0000_1220) begin failures++; $display("FAIL rd_address_o actual=%h required=00001220", bus.address_o); end
      bus.resp_i  = 1'b1;
      bus.burst_i = rd_beats[k];
      @(negedge clk);
    end
    bus.resp_i = 1'b0;
    checks++; if (bus.resp_o !== 1'b1) begin failures++; $display("FAIL rd_resp_cycle5 actual=%b required=1", bus.resp_o); end
    checks++; if (bus.read_o !== 1'b0) begin failures++; $display("FAIL rd_read_o_drop actual=%b required=0", bus.read_o); end
    checks++; if (bus.line_o !== rd_line) begin failures++; $display("FAIL rd_line_o actual=%h required=%h", bus.line_o, rd_line); end
    bus.read_i = 1'b0;
    @(negedge clk);
    checks++; if (bus.resp_o !== 1'b0) begin failures++; $display("FAIL rd_resp_single actual=%b required=0", bus.resp_o); end
  endtask

  task automatic test_write();
    bus.write_i   = 1'b1;
    bus.line_i    = wr_line;
    bus.address_i = 32'h0000_8055;
    @(negedge clk);
    for (int unsigned k = 0; k < 4; k++) begin
      checks++; if (bus.write_o !== 1'b1) begin failures++; $display("FAIL wr_write_o beat=%0d actual=%b required=1", k, bus.write_o); end
      checks++; if (bus.burst_o !== wr_beats[k]) begin failures++; $display("FAIL wr_burst_o beat=%0d actual=%h required=%h", k, bus.burst_o, wr_beats[k]); end
      checks++; if (bus.read_o !== 1'b0) begin failures++; $display("FAIL wr_read_o beat=%0d actual=%b required=0", k, bus.read_o); end
      bus.resp_i = 1'b1;
      @(negedge clk);
    end
    bus.resp_i = 1'b0;
    checks++; if (bus.write_o !== 1'b0) begin failures++; $display("FAIL wr_write_o_drop actual=%b required=0", bus.write_o); end
    checks++; if (bus.resp_o !== 1'b1) begin failures++; $display("FAIL wr_resp actual=%b required=1", bus.resp_o); end
    checks++; if (bus.address_o !== 32'h0000_8040) begin failures++; $display("FAIL wr_address_o actual=%h required=00008040", bus.address_o); end
    checks++; if (bus.line_o !== rd_line) begin failures++; $display("FAIL wr_line_o_kept actual=%h required=%h", bus.line_o, rd_line); end
    bus.write_i = 1'b0;
    @(negedge clk);
    checks++; if (bus.resp_o !== 1'b0) begin failures++; $display("FAIL wr_resp_single actual=%b required=0", bus.resp_o); end
  endtask

  task automatic test_read_gaps();
    bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    int unsigned bi = 0;
    bus.read_i    = 1'b1;
    bus.address_i = 32'h0000_0040;
    @(negedge clk);
    for (int unsigned k = 0; k < 7; k++) begin
      checks++; if (bus.read_o !== 1'b1) begin failures++; $display("FAIL gap_read_o cycle=%0d actual=%b required=1", k, bus.read_o); end
      checks++; if (bus.resp_o !== 1'b0) begin failures++; $display("FAIL gap_early_resp cycle=%0d actual=%b required=0", k, bus.resp_o); end
      bus.resp_i = pat[k];
      if (pat[k]) begin
        bus.burst_i = gp_beats[bi];
        bi++;
      end else begin
        bus.burst_i = 64'hDEAD_BEEF_DEAD_BEEF;
      end
      @(negedge clk);
    end
    bus.resp_i = 1'b0;
    checks++; if (bus.resp_o !== 1'b1) begin failures++; $display("FAIL gap_resp actual=%b required=1", bus.resp_o); end
    checks++; if (bus.read_o !== 1'b0) begin failures++; $display("FAIL gap_read_o_drop actual=%b required=0", bus.read_o); end
    checks++; if (bus.line_o !== gp_line) begin failures++; $display("FAIL gap_line_o actual=%h required=%h", bus.line_o, gp_line); end
    bus.read_i = 1'b0;
    @(negedge clk);
    checks++; if (bus.resp_o !== 1'b0) begin failures++; $display("FAIL gap_resp_single actual=%b required=0", bus.resp_o); end
  endtask

  task automatic test_both_high();
    bus.read_i    = 1'b1;
    bus.write_i   = 1'b1;
    bus.line_i    = wr_line;
    bus.address_i = 32'h0000_0100;
    @(negedge clk);
    for (int unsigned k = 0; k < 4; k++) begin
      checks++; if (bus.write_o !== 1'b0) begin failures++; $display("FAIL both_write_o beat=%0d actual=%b required=0", k, bus.write_o); end
      checks++; if (bus.read_o !== 1'b1) begin failures++; $display("FAIL both_read_o beat=%0d actual=%b required=1", k, bus.read_o); end
      bus.resp_i  = 1'b1;
      bus.burst_i = bh_beats[k];
      @(negedge clk);
    end
    bus.resp_i = 1'b0;
    checks++; if (bus.resp_o !== 1'b1) begin failures++; $display("FAIL both_resp actual=%b required=1", bus.resp_o); end
    checks++; if (bus.write_o !== 1'b0) begin failures++; $display("FAIL both_write_o_end actual=%b required=0", bus.write_o); end
    checks++; if (bus.line_o !== bh_line) begin failures++; $display("FAIL both_line_o actual=%h required=%h", bus.line_o, bh_line); end
    bus.read_i  = 1'b0;
    bus.write_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_burst();
    bus.read_i    = 1'b1;
    bus.address_i = 32'h0000_0200;
    @(negedge clk);
    for (int unsigned k = 0; k < 2; k++) begin
      bus.resp_i  = 1'b1;
      bus.burst_i = 64'hBAD0_0000_0000_0000 | 64'(k);
      @(negedge clk);
    end
    rst_n       = 1'b0;
    bus.resp_i  = 1'b0;
    bus.read_i  = 1'b0;
    @(negedge clk);
    checks++; if (bus.line_o !== '0) begin failures++; $display("FAIL mid_rst_line_o actual=%h required=0", bus.line_o); end
    checks++; if (bus.address_o !== '0) begin failures++; $display("FAIL mid_rst_address_o actual=%h required=0", bus.address_o); end
    checks++; if (bus.burst_o !== '0) begin failures++; $display("FAIL mid_rst_burst_o actual=%h required=0", bus.burst_o); end
    checks++; if (bus.read_o !== 1'b0) begin failures++; $display("FAIL mid_rst_read_o actual=%b required=0", bus.read_o); end
    checks++; if (bus.write_o !== 1'b0) begin failures++; $display("FAIL mid_rst_write_o actual=%b required=0", bus.write_o); end
    checks++; if (bus.resp_o !== 1'b0) begin failures++; $display("FAIL mid_rst_resp_o actual=%b required=0", bus.resp_o); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.resp_o !== 1'b0) begin failures++; $display("FAIL mid_rst_no_resp actual=%b required=0", bus.resp_o); end
    bus.read_i    = 1'b1;
    bus.address_i = 32'h0000_0300;
    @(negedge clk);
    for (int unsigned k = 0; k < 4; k++) begin
      bus.resp_i  = 1'b1;
      bus.burst_i = rs_beats[k];
      @(negedge clk);
    end
    bus.resp_i = 1'b0;
    checks++; if (bus.resp_o !== 1'b1) begin failures++; $display("FAIL mid_rst_new_resp actual=%b required=1", bus.resp_o); end
    checks++; if (bus.line_o !== rs_line) begin failures++; $display("FAIL mid_rst_new_line actual=%h required=%h", bus.line_o, rs_line); end
    checks++; if (bus.address_o !== 32'h0000_0300) begin failures++; $display("FAIL mid_rst_new_addr actual=%h required=00000300", bus.address_o); end
    bus.read_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bit done;
    bus.write_i   = 1'b1;
    bus.line_i    = bb_line;
    bus.address_i = 32'h0000_ABC7;
    mem_serve(done);
    bus.write_i = 1'b0;
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL b2b_write_timeout actual=%b required=1", done); end
    checks++; if ({mem[3], mem[2], mem[1], mem[0]} !== bb_line) begin failures++; $display("FAIL b2b_mem_line actual=%h required=%h", {mem[3], mem[2], mem[1], mem[0]}, bb_line); end
    @(negedge clk);
    bus.read_i    = 1'b1;
    bus.address_i = 32'h0000_ABC7;
    mem_serve(done);
    bus.read_i = 1'b0;
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL b2b_read_timeout actual=%b required=1", done); end
    checks++; if (bus.line_o !== bb_line) begin failures++; $display("FAIL b2b_line_o actual=%h required=%h", bus.line_o, bb_line); end
    checks++; if (bus.address_o !== 32'h0000_ABC0) begin failures++; $display("FAIL b2b_address_o actual=%h required=0000abc0", bus.address_o); end
    @(negedge clk);
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_read_zero_wait();
    test_write();
    test_read_gaps();
    test_both_high();
    test_reset_mid_burst();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
